// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 2-bit predictor counter encodings, PC step and default datapath width.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int PC_INC         = 4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter step: next value for a taken (inc) or not-taken outcome.
module sat_counter2
    import cpu_pkg::*;
(
    input  ctr_e ctr,
    input  logic inc,
    output ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_next = ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, trained from EX, plus
// saturating resolved-branch and misprediction counters.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ENTRIES    = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    output logic                  mispredict,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    logic [IDX-1:0]   if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit, upd_mispred;
    ctr_e             upd_ctr_next;
    logic [1:0]       unused_pc_lsbs;

    assign if_idx  = if_pc[IDX+1:2];
    assign if_tag  = if_pc[DATA_WIDTH-1:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[DATA_WIDTH-1:IDX+2];
    assign unused_pc_lsbs = upd_pc[1:0];

    // Lookup reads the pre-edge table contents; a same-cycle update is not bypassed.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + DATA_WIDTH'(PC_INC);

    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_mispred = upd_valid && (upd_taken != upd_pred_taken);

    sat_counter2 u_ctr (
        .ctr      (ctr_q[upd_idx]),
        .inc      (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // upd_valid is a single-cycle qualifier with no ready: every update is accepted on the
    // edge where it is high, unless reset (drops it) or flush (suppresses the table write).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= upd_mispred;
            if (upd_valid && branch_count != '1)
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (upd_mispred && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);

            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            end else if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_ctr_next;
                    if (upd_taken) target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target;
                    ctr_q[upd_idx]    <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int EW = 1 + DW + 1 + CW + CW;

    logic          clk = 1'b0;
    logic          rst, flush, upd_valid, upd_taken, upd_pred_taken;
    logic [DW-1:0] if_pc, upd_pc, upd_target;
    logic          pred_taken, mispredict;
    logic [DW-1:0] pred_target;
    logic [CW-1:0] branch_count, mispredict_count;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            compared = 0;
    int            mismatched = 0;

    always #5 clk = ~clk;

    branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(64), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // Drive one cycle of inputs and queue what the outputs must show during that cycle.
    task automatic cyc(input logic r, input logic f, input logic [DW-1:0] pc,
                       input logic uv, input logic [DW-1:0] upc, input logic ut,
                       input logic [DW-1:0] utg, input logic upt,
                       input logic ept, input logic [DW-1:0] etgt, input logic emp,
                       input logic [CW-1:0] ebc, input logic [CW-1:0] emc, input string nm);
        @(posedge clk);
        #1;
        rst = r; flush = f; if_pc = pc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_pred_taken = upt;
        exp_q.push_back({ept, etgt, emp, ebc, emc});
        name_q.push_back(nm);
    endtask

    function automatic logic [CW-1:0] sat(input int v);
        return (v > 15) ? 4'hF : CW'(v);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pred_taken, pred_target, mispredict, branch_count, mispredict_count};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s: got pt=%0b tgt=%h mp=%0b bc=%0d mc=%0d, expected pt=%0b tgt=%h mp=%0b bc=%0d mc=%0d",
                         nm, a[EW-1], a[EW-2 -: DW], a[2*CW], a[2*CW-1 -: CW], a[CW-1:0],
                         e[EW-1], e[EW-2 -: DW], e[2*CW], e[2*CW-1 -: CW], e[CW-1:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; if_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        cyc(1, 0, 32'h100, 0, 0, 0, 0, 0,  0, 32'h104, 0, 0, 0, "reset");
        // first taken branch allocates; same-cycle lookup sees the old entry
        cyc(0, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0,  0, 32'h104, 0, 0, 0, "alloc_same_cycle");
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0,  1, 32'h80, 1, 1, 1, "alloc_hit");
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0,  1, 32'h80, 0, 1, 1, "mp_pulse_end");
        // not-taken training: 10 -> 01 -> 00 -> 00
        cyc(0, 0, 32'h100, 1, 32'h100, 0, 0, 1,  1, 32'h80, 0, 1, 1, "nt1");
        cyc(0, 0, 32'h100, 1, 32'h100, 0, 0, 0,  0, 32'h104, 1, 2, 2, "nt2");
        cyc(0, 0, 32'h100, 1, 32'h100, 0, 0, 0,  0, 32'h104, 0, 3, 2, "nt3");
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0,  0, 32'h104, 0, 4, 2, "nt_sat");
        // from 00 one taken goes only to 01, still not-taken
        cyc(0, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0,  0, 32'h104, 0, 4, 2, "snt_inc");
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0,  0, 32'h104, 1, 5, 3, "snt_inc_chk");
        // alias: 0x200 evicts 0x100 at index 0; 0x300 not-taken miss leaves entry alone
        cyc(0, 0, 32'h200, 1, 32'h200, 1, 32'h400, 0,  0, 32'h204, 0, 5, 3, "alias_alloc");
        cyc(0, 0, 32'h100, 0, 0, 0, 0, 0,  0, 32'h104, 1, 6, 4, "alias_old_miss");
        cyc(0, 0, 32'h200, 1, 32'h300, 0, 0, 0,  1, 32'h400, 0, 6, 4, "alias_nt_miss");
        cyc(0, 0, 32'h200, 0, 0, 0, 0, 0,  1, 32'h400, 0, 7, 4, "alias_unchanged");
        cyc(0, 0, 32'h300, 0, 0, 0, 0, 0,  0, 32'h304, 0, 7, 4, "alias_300_miss");
        // taken hit moves 10 -> 11 and retargets; pc[1:0] ignored
        cyc(0, 0, 32'h204, 1, 32'h200, 1, 32'h500, 1,  0, 32'h208, 0, 7, 4, "hit_retarget");
        cyc(0, 0, 32'h202, 0, 0, 0, 0, 0,  1, 32'h500, 0, 8, 4, "lsb_ignored");
        cyc(0, 0, 32'h200, 1, 32'h200, 0, 0, 1,  1, 32'h500, 0, 8, 4, "st_dec");
        cyc(0, 0, 32'h200, 0, 0, 0, 0, 0,  1, 32'h500, 1, 9, 5, "st_dec_chk");
        // flush beats a same-cycle update; counters still move
        cyc(0, 1, 32'h200, 1, 32'h604, 1, 32'h700, 0,  1, 32'h500, 0, 9, 5, "flush_cycle");
        cyc(0, 0, 32'h200, 0, 0, 0, 0, 0,  0, 32'h204, 1, 10, 6, "flush_miss");
        cyc(0, 0, 32'h604, 0, 0, 0, 0, 0,  0, 32'h608, 0, 10, 6, "flush_no_write");
        // 20 mispredicted updates drive both 4-bit counters to saturation
        for (int k = 0; k < 20; k++)
            cyc(0, 0, 32'h800, 1, 32'h800, 0, 0, 1,  0, 32'h804, (k > 0), sat(10 + k), sat(6 + k), "sat_loop");
        cyc(0, 0, 32'h800, 0, 0, 0, 0, 0,  0, 32'h804, 1, 15, 15, "sat_hold");
        // reset with a live taken entry and an in-flight update
        cyc(0, 0, 32'h900, 1, 32'h900, 1, 32'hA00, 1,  0, 32'h904, 0, 15, 15, "pre_rst_alloc");
        cyc(1, 0, 32'h900, 1, 32'h900, 1, 32'hB00, 0,  0, 32'h904, 0, 15, 15, "rst_cycle");
        cyc(0, 0, 32'h900, 0, 0, 0, 0, 0,  0, 32'h904, 0, 0, 0, "post_rst");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
